board_vga_renderer: RTL

BOARD_VGA_RENDERER -- requirements
Module: board_vga_renderer

---
 rtl/board_vga_renderer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/board_vga_renderer.sv
// board_vga_renderer: VGA raster generator that draws a ROWS x COLS token
// board, a column-cursor bar and blinking winning cells from a per-frame
// snapshot of the game state.
module board_vga_renderer #(
  parameter int unsigned ROWS         = 6,
  parameter int unsigned COLS         = 7,
  parameter int unsigned CELL         = 60,
  parameter int unsigned PITCH        = 70,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned H_ACT        = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_TOT        = 800,
  parameter int unsigned V_ACT        = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_TOT        = 525
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS*COLS*2-1:0] panel,
  input  logic [ROWS*COLS-1:0]   win_mask,
  input  logic [COLS-1:0]        play,
  input  logic                   player,
  output logic                   hsync,
  output logic                   vsync,
  output logic [11:0]            rgb,
  output logic                   frame_start
);

  localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW   = $clog2(H_TOT);
  localparam int unsigned VW   = $clog2(V_TOT);
  localparam int unsigned FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned ORG  = 20;
  localparam int unsigned HALF = CELL / 2;
  localparam int unsigned RAD  = CELL / 2 - 4;
  localparam int unsigned RAD2 = RAD * RAD;

  logic [DW-1:0]          div_q, div_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic [VW-1:0]          vcnt_q, vcnt_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   bph_q, bph_d;
  logic [ROWS*COLS*2-1:0] panel_s_q, panel_s_d;
  logic [ROWS*COLS-1:0]   win_s_q, win_s_d;
  logic [COLS-1:0]        play_s_q, play_s_d;
  logic                   player_s_q, player_s_d;
  logic [11:0]            s1_rgb_q, s1_rgb_d, s2_rgb_q, s2_rgb_d;
  logic                   s1_hs_q, s1_hs_d, s2_hs_q, s2_hs_d;
  logic                   s1_vs_q, s1_vs_d, s2_vs_q, s2_vs_d;

  logic        pt, snap;
  logic        hs_raw, vs_raw;
  logic [11:0] pix;
  logic        in_col, in_row, bar_col, bar_band, token, win;
  logic [1:0]  code;
  int unsigned hx, vy, col, row, dx, dy, ddx, ddy;

  // Pixel tick and snapshot strobe
  always_comb begin
    pt   = (div_q == DW'(CLK_DIV - 1));
    snap = pt && (hcnt_q == '0) && (vcnt_q == VW'(V_ACT));
  end

  assign frame_start = snap;

  // Per-pixel colour and raw sync, drawn only from the shadowed state
  always_comb begin
    hx       = 32'(hcnt_q);
    vy       = 32'(vcnt_q);
    in_col   = 1'b0;
    col      = 0;
    dx       = 0;
    bar_col  = 1'b0;
    for (int unsigned j = 0; j < COLS; j++) begin
      if (hx >= ORG + PITCH * j && hx < ORG + PITCH * j + CELL) begin
        in_col  = 1'b1;
        col     = j;
        dx      = hx - (ORG + PITCH * j);
        bar_col = 1'(play_s_q >> j);
      end
    end
    in_row = 1'b0;
    row    = 0;
    dy     = 0;
    // screen row 0 is the top of the board, which is the highest panel row
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (vy >= ORG + PITCH * i && vy < ORG + PITCH * i + CELL) begin
        in_row = 1'b1;
        row    = ROWS - 1 - i;
        dy     = vy - (ORG + PITCH * i);
      end
    end
    code     = 2'(panel_s_q >> (2 * (row * COLS + col)));
    win      = 1'(win_s_q >> (row * COLS + col));
    ddx      = (dx >= HALF) ? dx - HALF : HALF - dx;
    ddy      = (dy >= HALF) ? dy - HALF : HALF - dy;
    token    = in_col && in_row && (ddx * ddx + ddy * ddy < RAD2);
    bar_band = (vy >= V_ACT - 30) && (vy < V_ACT - 10);

    pix = 12'h00F;
    if (bar_band && bar_col) pix = player_s_q ? 12'hF00 : 12'h0F0;
    if (token) begin
      case (code)
        2'b00:   pix = 12'h000;
        2'b01:   pix = 12'h0F0;
        2'b10:   pix = 12'hF00;
        default: pix = 12'hFF0;
      endcase
      if (win && bph_q) pix = 12'hFFF;
    end
    // the bottom margin is blank except for the indicator strip
    if (hx >= H_ACT || vy >= V_ACT || hx < 10 || hx >= H_ACT - 10 || vy < 10 ||
        (vy >= V_ACT - 40 && !bar_band)) pix = 12'h000;

    hs_raw = (hx >= H_ACT + H_FP) && (hx < H_ACT + H_FP + H_SYNC);
    vs_raw = (vy >= V_ACT + V_FP) && (vy < V_ACT + V_FP + V_SYNC);
  end

  // Divider, raster counters, snapshot/blink state and output pipeline
  always_comb begin
    div_d      = div_q + 1'b1;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    fcnt_d     = fcnt_q;
    bph_d      = bph_q;
    panel_s_d  = panel_s_q;
    win_s_d    = win_s_q;
    play_s_d   = play_s_q;
    player_s_d = player_s_q;
    s1_rgb_d   = s1_rgb_q;
    s1_hs_d    = s1_hs_q;
    s1_vs_d    = s1_vs_q;
    s2_rgb_d   = s2_rgb_q;
    s2_hs_d    = s2_hs_q;
    s2_vs_d    = s2_vs_q;
    if (pt) begin
      div_d = '0;
      if (hcnt_q == HW'(H_TOT - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VW'(V_TOT - 1)) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
      s1_rgb_d = pix;
      s1_hs_d  = hs_raw;
      s1_vs_d  = vs_raw;
      s2_rgb_d = s1_rgb_q;
      s2_hs_d  = s1_hs_q;
      s2_vs_d  = s1_vs_q;
    end
    if (snap) begin
      panel_s_d  = panel;
      win_s_d    = win_mask;
      play_s_d   = play;
      player_s_d = player;
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // State registers; sync stages hold "sync asserted" so reset gives idle-high pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      fcnt_q     <= '0;
      bph_q      <= 1'b0;
      panel_s_q  <= '0;
      win_s_q    <= '0;
      play_s_q   <= '0;
      player_s_q <= 1'b0;
      s1_rgb_q   <= '0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s2_rgb_q   <= '0;
      s2_hs_q    <= 1'b0;
      s2_vs_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      fcnt_q     <= fcnt_d;
      bph_q      <= bph_d;
      panel_s_q  <= panel_s_d;
      win_s_q    <= win_s_d;
      play_s_q   <= play_s_d;
      player_s_q <= player_s_d;
      s1_rgb_q   <= s1_rgb_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s2_rgb_q   <= s2_rgb_d;
      s2_hs_q    <= s2_hs_d;
      s2_vs_q    <= s2_vs_d;
    end
  end

  assign rgb   = s2_rgb_q;
  assign hsync = ~s2_hs_q;
  assign vsync = ~s2_vs_q;

endmodule
